// File: rtl/mult_pkg.sv
// Shared constants for the nibble-serial multiplier: nibble/product widths,
// FSM state encodings and the partial-product shift helper.
package mult_pkg;

  localparam int NIB_W = 4;
  localparam int PP_W  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Weight of the product of lhs nibble i and rhs nibble j.
  function automatic int nib_shift(input int i, input int j);
    return NIB_W * (i + j);
  endfunction

endpackage

// File: rtl/nibble_lut4x4.sv
// Combinational 4x4 -> 8 multiplier as a 256-entry table indexed by {a, b}.
module nibble_lut4x4
  import mult_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [PP_W-1:0]  p
);

  logic [PP_W-1:0] rom [256];

  for (genvar k = 0; k < 256; k++) begin : g_rom
    assign rom[k] = PP_W'((k / 16) * (k % 16));
  end

  assign p = rom[{a, b}];

endmodule

// File: rtl/mult_seq_nibble.sv
// Sequential WIDTH x WIDTH unsigned multiplier, one nibble pair per cycle.
// Optional MULT_SEQ_ZERO_SKIP_EN: zero operands skip straight to DONE.
module mult_seq_nibble
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [WIDTH-1:0]   io_in_lhs,
  input  logic [WIDTH-1:0]   io_in_rhs,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [2*WIDTH-1:0] io_out_data
);

  localparam int NIB   = WIDTH / 4;
  localparam int NPP   = NIB * NIB;
  localparam int IDX_W = (NPP > 1) ? $clog2(NPP) : 1;
  localparam int ACC_W = 2 * WIDTH;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] lhs_q;
  logic [WIDTH-1:0] rhs_q;
  logic [ACC_W-1:0] acc;

  int               i_idx;
  int               j_idx;
  logic [NIB_W-1:0] lhs_nib;
  logic [NIB_W-1:0] rhs_nib;
  logic [PP_W-1:0]  pp;
  logic [ACC_W-1:0] addend;
  logic             accept;
  logic             last_pp;

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);
  assign io_out_data  = acc;
  assign accept       = io_in_valid && io_in_ready;
  assign last_pp      = (idx == IDX_W'(NPP - 1));

  // idx walks rhs nibbles fastest, lhs nibbles slowest.
  always_comb begin
    i_idx   = int'(idx) / NIB;
    j_idx   = int'(idx) % NIB;
    lhs_nib = NIB_W'(lhs_q >> (NIB_W * i_idx));
    rhs_nib = NIB_W'(rhs_q >> (NIB_W * j_idx));
    addend  = ACC_W'(pp) << nib_shift(i_idx, j_idx);
  end

  nibble_lut4x4 u_lut (
    .a (lhs_nib),
    .b (rhs_nib),
    .p (pp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      lhs_q <= '0;
      rhs_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lhs_q <= io_in_lhs;
            rhs_q <= io_in_rhs;
            acc   <= '0;
            idx   <= '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if ((io_in_lhs == '0) || (io_in_rhs == '0)) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (last_pp) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_seq_nibble.md
Name: mult_seq_nibble

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier built on a 4x4 lookup-table nibble multiplier.
- Sits directly upstream of the 4x4 table stage: splits wide operands into nibble pairs, feeds one pair per cycle, and shift-accumulates the 8-bit products.
- Valid/ready on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.
- NIB (derived), WIDTH/4, nibbles per operand.
- NPP (derived), NIB*NIB, number of partial products, one per RUN cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  1  operand pair valid.
- io_in_ready  out  1  block can accept; high only in IDLE.
- io_in_lhs  in  WIDTH  unsigned multiplicand.
- io_in_rhs  in  WIDTH  unsigned multiplier.
- io_out_valid  out  1  result valid; high only in DONE.
- io_out_ready  in  1  consumer accepts result.
- io_out_data  out  2*WIDTH  product, equal to the accumulator register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, accumulator=0, idx=0, io_out_valid=0, io_in_ready=1 from the first cycle after reset. Reset dominates every other event.
- States: IDLE, RUN, DONE.
- IDLE:
  - io_in_ready=1.
  - On io_in_valid&io_in_ready: latch lhs/rhs, accumulator=0, idx=0, go to RUN.
- RUN:
  - io_in_ready=0, io_out_valid=0.
  - Each cycle: i=idx/NIB (lhs nibble), j=idx%NIB (rhs nibble).
  - accumulator += zero-extend(lut(lhs[4i+:4], rhs[4j+:4])) << 4*(i+j), computed at 2*WIDTH bits. The sum never overflows.
  - idx increments each cycle. When idx==NPP-1, go to DONE on that edge.
- Latency: accepting edge E0; products accumulate on edges E1..E_NPP; io_out_valid is high after E_NPP. WIDTH=8 gives 4 cycles.
- DONE:
  - io_out_valid=1. io_out_data holds stable until io_out_ready.
  - On io_out_valid&io_out_ready: go to IDLE.
  - io_in_ready is 0 in DONE. Input accepted the cycle after the result handshake.
  - Throughput: one operation per NPP+2 cycles with both sides always ready.
- io_out_data keeps the last result through IDLE; cleared on the next accept.
- io_in_valid in RUN/DONE is ignored; operands are not re-sampled.
- Reset in RUN or DONE: abandon the operation, no io_out_valid pulse, normal IDLE next cycle.
- lut is exact: lut(a,b)=a*b, 8-bit, a/b in 0..15.

Optional Feature:
- Macro MULT_SEQ_ZERO_SKIP_EN.
- Defined: at accept, if lhs==0 or rhs==0, go straight from IDLE to DONE with accumulator=0. Latency is 1 cycle.
- Undefined: zero operands take the full NPP RUN cycles. Result is still 0.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package mult_pkg:
  - NIB_W=4, PP_W=8.
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Function returning the nibble shift 4*(i+j).
- Sub-module nibble_lut4x4: combinational 256-entry 4x4->8 table, index {a,b}, initialised with a*b. Instantiated once.
- Top contains FSM, idx counter, operand registers, shifter and accumulator.

Test Plan:
1. Reset, then lhs=0xFF, rhs=0xFF, out_ready=1 -> io_out_valid high exactly 4 cycles after the accept edge, io_out_data=0xFE01, then io_in_ready=1.
2. 0x12*0x34 -> 0x03A8. Check io_out_data before the result handshake.
3. Backpressure: 0x0A*0x0B with out_ready=0 for 3 cycles after valid -> io_out_data=0x006E stable, io_in_ready=0, new in_valid with other operands ignored. Release -> IDLE next cycle.
4. Reset in the 2nd RUN cycle of 0xC3*0x5A -> no io_out_valid, io_in_ready=1 next cycle. The following 0x07*0x09 gives 0x003F.
5. 0x00*0x5A -> data 0x0000. Latency 1 with MULT_SEQ_ZERO_SKIP_EN, latency 4 without.
6. Streaming with in_valid/out_ready held high: 0x01*0x01=0x0001, 0x80*0x02=0x0100, 0xF0*0x0F=0x0E10. Results in order, one per 6 cycles. WIDTH=16 regression: 0xFFFF*0xFFFF=0xFFFE0001 after 16 cycles.
